uart_frame_check: RTL and testbench
===================================

Name: uart_frame_check

Overview:
Parametrised end-of-frame checker for the UART RX path. Generalises the single-bit stop check into a small sequencer that checks an optional parity bit and 1..STOP_BITS_MAX stop bits, then reports per-frame error flags. It also keeps saturating error counters for the register file. It sits between the RX FSM/data sampler and the RX output interface.

Parameters:
DATA_WIDTH, 8, width of the received data word used for parity computation
STOP_BITS_MAX, 2, maximum number of stop bits supported (>=1)
ERR_CNT_WIDTH, 8, width of each saturating error counter
TIMEOUT_CYC, 1024, idle-cycle limit between bit strobes; used only with UART_CHK_TIMEOUT_EN

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
chk_start  in  1  one-cycle pulse from the RX FSM after the last data bit; latches p_data and configuration
p_data  in  DATA_WIDTH  received data word, valid when chk_start=1
par_en  in  1  parity bit present, sampled at chk_start
par_typ  in  1  0=even, 1=odd, sampled at chk_start
stop_bits  in  $clog2(STOP_BITS_MAX+1)  number of stop bits, sampled at chk_start; 0 is treated as 1, values >STOP_BITS_MAX are clamped
bit_vld  in  1  one-cycle strobe: sampled_bit holds the next post-data bit
sampled_bit  in  1  majority-sampled line value
frame_done  out  1  one-cycle pulse at the end of the check
par_err  out  1  parity error for the last frame; held until the next chk_start
stp_err  out  1  stop error (any stop bit = 0) for the last frame; held until the next chk_start
busy  out  1  high from chk_start until frame_done
cnt_clr  in  1  synchronous clear of both counters
par_err_cnt  out  ERR_CNT_WIDTH  saturating count of parity-errored frames
stp_err_cnt  out  ERR_CNT_WIDTH  saturating count of stop-errored frames

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RST. While RST=1, every output is 0, the counters are 0, and the state is IDLE.
- FSM states: IDLE, PAR, STOP, DONE.
- IDLE:
  - On chk_start: latch p_data, par_typ and the effective stop count N.
  - Clear par_err, stp_err and the stop-bit index.
  - Go to PAR if par_en, else go to STOP.
- PAR:
  - On bit_vld: expected = ^p_data ^ par_typ.
  - par_err_n = (sampled_bit != expected).
  - Go to STOP.
- STOP:
  - On each bit_vld: if sampled_bit=0, set the internal stp_err_n sticky bit; increment the index.
  - After the Nth stop bit, go to DONE.
- DONE (one cycle):
  - frame_done=1.
  - par_err and stp_err are loaded from the internal bits.
  - Counters increment by 1 for each errored type, saturating at all-ones.
  - Go to IDLE.
- Error flag timing: error outputs update in the same cycle frame_done is high; nothing reports them early.
- busy: high in PAR, STOP and DONE.
- Latency: frame_done is asserted 1 cycle after the last required bit_vld.
- bit_vld in IDLE or DONE: ignored.
- chk_start while busy (any state except IDLE):
  - Abort the current frame; no frame_done and no counter update for it.
  - Restart with the newly latched data and configuration.
- chk_start together with bit_vld: chk_start wins and bit_vld is ignored.
- cnt_clr together with a counter increment: clear wins and the counter becomes 0.
- Counter saturation: the counter stays at 2^ERR_CNT_WIDTH-1. No wrap.
- Reset mid-frame: immediate return to IDLE; all flags and counters are 0 on the next cycle.

Optional Feature:
UART_CHK_TIMEOUT_EN
- Defined:
  - An idle counter runs while busy and resets on every bit_vld and on chk_start.
  - If it reaches TIMEOUT_CYC-1 in PAR or STOP, the FSM goes to DONE with stp_err forced to 1.
  - An added output chk_timeout (1 bit) pulses together with frame_done. The stop counter increments as for a normal stop error.
- Undefined:
  - No idle counter and no chk_timeout port.
  - The FSM waits indefinitely for bit_vld.

Decomposition:
- Package uart_chk_pkg:
  - FSM state enum (IDLE, PAR, STOP, DONE).
  - Parity type constants PAR_EVEN=0, PAR_ODD=1.
  - Function computing the expected parity bit from data and type.
- One sub-module, uart_sat_cnt (parameter WIDTH; inputs inc and clr, clr priority), instantiated twice.

Test Plan:
- Frame checks:
  - par_en=1, par_typ=0, p_data=8'hA5, stop_bits=1, bits 0 then 1 -> frame_done 1 cycle after the 2nd bit_vld; par_err=0, stp_err=0; counters stay 0.
  - par_en=1, par_typ=1, p_data=8'h01, parity bit 1, stop 1 -> par_err=1, par_err_cnt=1, stp_err=0.
  - par_en=0, stop_bits=2, stop bits 1 then 0 -> stp_err=1 only after the 2nd bit_vld; frame_done is not asserted after the 1st; stp_err_cnt=1.
- Abort and priority:
  - chk_start, one bit_vld, then chk_start again with p_data=8'hFF -> no frame_done for the first frame; the second frame completes normally.
  - chk_start in the same cycle as bit_vld -> bit_vld ignored; busy=1.
- Counters and reset:
  - ERR_CNT_WIDTH=2: 5 stop-errored frames -> stp_err_cnt holds 3.
  - cnt_clr in the same cycle as an increment -> counter 0.
  - RST asserted in STOP -> next cycle all outputs 0 and busy=0.

Source files
------------

// File: rtl/uart_frame_check_pkg.sv
// Shared types and helpers for the UART end-of-frame checker.
// Holds the FSM state enum, the parity-type constants and the expected-parity function.
package uart_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAR,
    STOP,
    DONE
  } chk_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Data is zero-extended by the caller, which leaves the XOR reduction unchanged.
  function automatic logic exp_par(input logic [63:0] data,
                                   input logic        typ);
    return (^data) ^ typ;
  endfunction

endpackage

// File: rtl/uart_frame_check_if.sv
// RX FSM to frame-checker bundle: frame start/config, bit strobes and per-frame results.
// master = RX FSM side, slave = checker side.
interface uart_chk_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int STOP_BITS_MAX = 2
);
  localparam int SW = $clog2(STOP_BITS_MAX + 1);

  logic                  chk_start;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  par_en;
  logic                  par_typ;
  logic [SW-1:0]         stop_bits;
  logic                  bit_vld;
  logic                  sampled_bit;
  logic                  frame_done;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  modport master (
    output chk_start, p_data, par_en, par_typ,
    output stop_bits, bit_vld, sampled_bit,
    input  frame_done, par_err, stp_err, busy
  );

  modport slave (
    input  chk_start, p_data, par_en, par_typ,
    input  stop_bits, bit_vld, sampled_bit,
    output frame_done, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_frame_check_sat_cnt.sv
// Saturating up-counter used for the per-type error counts.
// Ports: CLK, RST (sync high), inc, clr (wins over inc), cnt.
module uart_sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_frame_check.sv
// End-of-frame checker: optional parity bit, 1..STOP_BITS_MAX stop bits, error flags and counters.
// Ports: CLK, RST, chk (uart_chk_if.slave), cnt_clr, par_err_cnt, stp_err_cnt; chk_timeout with UART_CHK_TIMEOUT_EN.
module uart_frame_check
  import uart_chk_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int STOP_BITS_MAX = 2,
  parameter int ERR_CNT_WIDTH = 8,
  parameter int TIMEOUT_CYC   = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  uart_chk_if.slave                chk,
`ifdef UART_CHK_TIMEOUT_EN
  output logic                     chk_timeout,
`endif
  input  logic                     cnt_clr,
  output logic [ERR_CNT_WIDTH-1:0] par_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0] stp_err_cnt
);

  localparam int SW = $clog2(STOP_BITS_MAX + 1);

  chk_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  typ_q, typ_d;
  logic [SW-1:0]         n_q, n_d;
  logic [SW-1:0]         idx_q, idx_d;
  logic                  par_bad_q, par_bad_d;
  logic                  stp_bad_q, stp_bad_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic [SW-1:0]         n_eff;
  logic                  done;

`ifdef UART_CHK_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          to_q, to_d;
  logic          tmo_hit;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign chk_timeout = done & to_q;
`endif

  always_comb begin
    n_eff = chk.stop_bits;
    if (chk.stop_bits == '0) begin
      n_eff = SW'(1);
    end else if (chk.stop_bits > SW'(STOP_BITS_MAX)) begin
      n_eff = SW'(STOP_BITS_MAX);
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    typ_d     = typ_q;
    n_d       = n_q;
    idx_d     = idx_q;
    par_bad_d = par_bad_q;
    stp_bad_d = stp_bad_q;
    par_err_d = par_err_q;
    stp_err_d = stp_err_q;
`ifdef UART_CHK_TIMEOUT_EN
    to_d      = to_q;
`endif
    // A new start always wins: it aborts any frame in flight and masks bit_vld.
    if (chk.chk_start) begin
      data_d    = chk.p_data;
      typ_d     = chk.par_typ;
      n_d       = n_eff;
      idx_d     = '0;
      par_bad_d = 1'b0;
      stp_bad_d = 1'b0;
      par_err_d = 1'b0;
      stp_err_d = 1'b0;
`ifdef UART_CHK_TIMEOUT_EN
      to_d      = 1'b0;
`endif
      state_d   = chk.par_en ? PAR : STOP;
    end else begin
      unique case (state_q)
        IDLE: ;
        PAR: begin
          if (chk.bit_vld) begin
            par_bad_d = chk.sampled_bit !=
                        exp_par(64'(data_q), typ_q);
            state_d   = STOP;
          end
`ifdef UART_CHK_TIMEOUT_EN
          else if (tmo_hit) begin
            par_err_d = par_bad_q;
            stp_err_d = 1'b1;
            to_d      = 1'b1;
            state_d   = DONE;
          end
`endif
        end
        STOP: begin
          if (chk.bit_vld) begin
            stp_bad_d = stp_bad_q | ~chk.sampled_bit;
            idx_d     = idx_q + SW'(1);
            // Flags load on entry to DONE so they show with frame_done.
            if (idx_d == n_q) begin
              par_err_d = par_bad_q;
              stp_err_d = stp_bad_d;
              state_d   = DONE;
            end
          end
`ifdef UART_CHK_TIMEOUT_EN
          else if (tmo_hit) begin
            par_err_d = par_bad_q;
            stp_err_d = 1'b1;
            to_d      = 1'b1;
            state_d   = DONE;
          end
`endif
        end
        DONE: state_d = IDLE;
      endcase
    end
  end

`ifdef UART_CHK_TIMEOUT_EN
  always_comb begin
    tmo_d = tmo_q + TW'(1);
    if (chk.chk_start || chk.bit_vld || (state_q == IDLE)) begin
      tmo_d = '0;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      data_q    <= '0;
      typ_q     <= PAR_EVEN;
      n_q       <= '0;
      idx_q     <= '0;
      par_bad_q <= 1'b0;
      stp_bad_q <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
`ifdef UART_CHK_TIMEOUT_EN
      tmo_q     <= '0;
      to_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      typ_q     <= typ_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      par_bad_q <= par_bad_d;
      stp_bad_q <= stp_bad_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
`ifdef UART_CHK_TIMEOUT_EN
      tmo_q     <= tmo_d;
      to_q      <= to_d;
`endif
    end
  end

  // A start arriving in DONE aborts that frame, so it is not reported.
  assign done           = (state_q == DONE) & ~chk.chk_start;
  assign chk.frame_done = done;
  assign chk.busy       = (state_q != IDLE);
  assign chk.par_err    = par_err_q;
  assign chk.stp_err    = stp_err_q;

  uart_sat_cnt #(.WIDTH(ERR_CNT_WIDTH)) u_par_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (done & par_err_q),
    .clr (cnt_clr),
    .cnt (par_err_cnt)
  );

  uart_sat_cnt #(.WIDTH(ERR_CNT_WIDTH)) u_stp_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (done & stp_err_q),
    .clr (cnt_clr),
    .cnt (stp_err_cnt)
  );

endmodule

// File: tb/tb_uart_frame_check.sv
// Directed bench for uart_frame_check with 2-bit counters to reach saturation.
// Inputs change 1 ns after each rising edge; outputs are checked at the same point.
module tb_uart_frame_check;

  logic       CLK;
  logic       RST;
  logic       cnt_clr;
  logic [1:0] par_err_cnt;
  logic [1:0] stp_err_cnt;
  int         checks;
  int         errors;

  uart_chk_if #(.DATA_WIDTH(8), .STOP_BITS_MAX(2)) bus ();

  uart_frame_check #(
    .DATA_WIDTH    (8),
    .STOP_BITS_MAX (2),
    .ERR_CNT_WIDTH (2),
    .TIMEOUT_CYC   (1024)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .chk         (bus),
    .cnt_clr     (cnt_clr),
    .par_err_cnt (par_err_cnt),
    .stp_err_cnt (stp_err_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] d, input logic pen,
                       input logic ptyp, input logic [1:0] sb);
    bus.p_data    = d;
    bus.par_en    = pen;
    bus.par_typ   = ptyp;
    bus.stop_bits = sb;
    bus.chk_start = 1'b1;
    tick();
    bus.chk_start = 1'b0;
  endtask

  task automatic send(input logic b);
    bus.bit_vld     = 1'b1;
    bus.sampled_bit = b;
    tick();
    bus.bit_vld     = 1'b0;
    bus.sampled_bit = 1'b1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    RST             = 1'b1;
    cnt_clr         = 1'b0;
    bus.chk_start   = 1'b0;
    bus.p_data      = '0;
    bus.par_en      = 1'b0;
    bus.par_typ     = 1'b0;
    bus.stop_bits   = '0;
    bus.bit_vld     = 1'b0;
    bus.sampled_bit = 1'b1;
    tick();
    tick();
    chk("rst_busy", 8'(bus.busy), 8'h0);
    chk("rst_done", 8'(bus.frame_done), 8'h0);
    chk("rst_perr", 8'(bus.par_err), 8'h0);
    chk("rst_serr", 8'(bus.stp_err), 8'h0);
    chk("rst_pcnt", 8'(par_err_cnt), 8'h0);
    chk("rst_scnt", 8'(stp_err_cnt), 8'h0);
    RST = 1'b0;
    tick();

    // A5 has even weight: even parity bit 0 is correct.
    start(8'hA5, 1'b1, 1'b0, 2'd1);
    chk("a_busy", 8'(bus.busy), 8'h1);
    send(1'b0);
    chk("a_nodone", 8'(bus.frame_done), 8'h0);
    send(1'b1);
    chk("a_done", 8'(bus.frame_done), 8'h1);
    chk("a_perr", 8'(bus.par_err), 8'h0);
    chk("a_serr", 8'(bus.stp_err), 8'h0);
    tick();
    chk("a_done_off", 8'(bus.frame_done), 8'h0);
    chk("a_idle", 8'(bus.busy), 8'h0);
    chk("a_pcnt", 8'(par_err_cnt), 8'h0);
    chk("a_scnt", 8'(stp_err_cnt), 8'h0);

    // 01 odd weight, odd parity expects 0; a 1 is an error.
    start(8'h01, 1'b1, 1'b1, 2'd1);
    send(1'b1);
    send(1'b1);
    chk("b_done", 8'(bus.frame_done), 8'h1);
    chk("b_perr", 8'(bus.par_err), 8'h1);
    chk("b_serr", 8'(bus.stp_err), 8'h0);
    tick();
    chk("b_pcnt", 8'(par_err_cnt), 8'h1);
    chk("b_scnt", 8'(stp_err_cnt), 8'h0);
    chk("b_hold", 8'(bus.par_err), 8'h1);

    start(8'h00, 1'b0, 1'b0, 2'd2);
    chk("c_clr", 8'(bus.par_err), 8'h0);
    send(1'b1);
    chk("c_nodone", 8'(bus.frame_done), 8'h0);
    chk("c_early", 8'(bus.stp_err), 8'h0);
    send(1'b0);
    chk("c_done", 8'(bus.frame_done), 8'h1);
    chk("c_serr", 8'(bus.stp_err), 8'h1);
    chk("c_perr", 8'(bus.par_err), 8'h0);
    tick();
    chk("c_scnt", 8'(stp_err_cnt), 8'h1);
    chk("c_pcnt", 8'(par_err_cnt), 8'h1);

    // Abort: second start must restart in PAR, not finish the first frame.
    start(8'h12, 1'b1, 1'b0, 2'd1);
    send(1'b0);
    start(8'hFF, 1'b1, 1'b0, 2'd1);
    chk("d_nodone", 8'(bus.frame_done), 8'h0);
    chk("d_busy", 8'(bus.busy), 8'h1);
    send(1'b0);
    chk("d_nodone2", 8'(bus.frame_done), 8'h0);
    send(1'b1);
    chk("d_done", 8'(bus.frame_done), 8'h1);
    chk("d_perr", 8'(bus.par_err), 8'h0);
    chk("d_serr", 8'(bus.stp_err), 8'h0);
    tick();
    chk("d_scnt", 8'(stp_err_cnt), 8'h1);

    // Start with a coincident zero bit: the bit must be dropped.
    start(8'h00, 1'b1, 1'b0, 2'd1);
    bus.bit_vld     = 1'b1;
    bus.sampled_bit = 1'b0;
    start(8'h00, 1'b0, 1'b0, 2'd1);
    bus.bit_vld     = 1'b0;
    bus.sampled_bit = 1'b1;
    chk("e_busy", 8'(bus.busy), 8'h1);
    chk("e_nodone", 8'(bus.frame_done), 8'h0);
    send(1'b1);
    chk("e_done", 8'(bus.frame_done), 8'h1);
    chk("e_serr", 8'(bus.stp_err), 8'h0);
    tick();

    // stop_bits=0 acts as 1; stop_bits=3 clamps to 2.
    start(8'h00, 1'b0, 1'b0, 2'd0);
    send(1'b1);
    chk("f_sb0", 8'(bus.frame_done), 8'h1);
    tick();
    start(8'h00, 1'b0, 1'b0, 2'd3);
    send(1'b1);
    chk("f_sb3a", 8'(bus.frame_done), 8'h0);
    send(1'b1);
    chk("f_sb3b", 8'(bus.frame_done), 8'h1);
    tick();

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("g_clr", 8'(stp_err_cnt), 8'h0);
    for (int i = 0; i < 5; i++) begin
      start(8'h00, 1'b0, 1'b0, 2'd1);
      send(1'b0);
      tick();
    end
    chk("g_sat", 8'(stp_err_cnt), 8'h3);

    // Clear in the DONE cycle beats the increment.
    start(8'h00, 1'b0, 1'b0, 2'd1);
    send(1'b0);
    chk("h_done", 8'(bus.frame_done), 8'h1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("h_scnt", 8'(stp_err_cnt), 8'h0);
    chk("h_pcnt", 8'(par_err_cnt), 8'h0);

    start(8'h00, 1'b0, 1'b0, 2'd1);
    send(1'b0);
    tick();
    chk("i_pre", 8'(stp_err_cnt), 8'h1);
    start(8'h00, 1'b0, 1'b0, 2'd2);
    send(1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("i_busy", 8'(bus.busy), 8'h0);
    chk("i_done", 8'(bus.frame_done), 8'h0);
    chk("i_serr", 8'(bus.stp_err), 8'h0);
    chk("i_scnt", 8'(stp_err_cnt), 8'h0);
    send(1'b0);
    chk("i_idle", 8'(bus.busy), 8'h0);
    chk("i_nodone", 8'(bus.frame_done), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
